// File: rtl/bcd999_pkg.sv
// Shared types and BCD helpers for the bcd999_ctrl counter.
package bcd999_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    function automatic logic is_bcd12(input logic [11:0] v);
        return (v[3:0] <= BCD_MAX_DIGIT) && (v[7:4] <= BCD_MAX_DIGIT) &&
               (v[11:8] <= BCD_MAX_DIGIT);
    endfunction

    // Value the chain will hold after one increment; 999 rolls to 000.
    function automatic logic [11:0] bcd_inc12(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != BCD_MAX_DIGIT) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != BCD_MAX_DIGIT) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = (v[11:8] == BCD_MAX_DIGIT) ? 4'd0 : v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd999_digit.sv
// One BCD decade: clear beats load beats enable; carry_o feeds the next decade.
module bcd_digit
    import bcd999_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] digit,
    output logic       carry_o
);

    assign carry_o = en && (digit == BCD_MAX_DIGIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_val;
        end else if (en) begin
            digit <= carry_o ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/bcd999_ctrl.sv
// Run/stop/clear/preset controller around a three-decade BCD count chain.
module bcd999_ctrl
    import bcd999_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [11:0] load_val_i,
    input  logic [11:0] target_i,
    input  logic        wrap_mode_i,
    output logic [3:0]  q1_o,
    output logic [3:0]  q2_o,
    output logic [3:0]  q3_o,
    output logic        running_o,
    output logic        done_o,
    output logic        wrap_o,
    output logic        err_o,
    output logic [1:0]  state_o
);

    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_t        state, state_next;
    logic [PW-1:0] presc, presc_next;
    logic [11:0]   target_q;
    logic          mode_q;
    logic [11:0]   count;
    logic          cnt_clr, cnt_load, cnt_inc;
    logic          latch_tgt, err_set, done_set, wrap_set;
    logic          carry_u, carry_t, carry_h;

    assign count     = {q3_o, q2_o, q1_o};
    assign running_o = (state == RUN);
    assign state_o   = state;

    bcd_digit u_units (
        .clk(clk), .rst(rst), .clr(cnt_clr), .load(cnt_load),
        .load_val(load_val_i[3:0]), .en(cnt_inc), .digit(q1_o), .carry_o(carry_u)
    );
    bcd_digit u_tens (
        .clk(clk), .rst(rst), .clr(cnt_clr), .load(cnt_load),
        .load_val(load_val_i[7:4]), .en(carry_u), .digit(q2_o), .carry_o(carry_t)
    );
    bcd_digit u_hund (
        .clk(clk), .rst(rst), .clr(cnt_clr), .load(cnt_load),
        .load_val(load_val_i[11:8]), .en(carry_t), .digit(q3_o), .carry_o(carry_h)
    );

    // Branch order encodes command priority: clear, load, stop, start.
    always_comb begin
        state_next = state;
        presc_next = presc;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        latch_tgt  = 1'b0;
        err_set    = 1'b0;
        done_set   = 1'b0;
        wrap_set   = 1'b0;
        if (clear_i) begin
            state_next = IDLE;
            presc_next = '0;
            cnt_clr    = 1'b1;
        end else if (load_i && state != RUN) begin
            if (!is_bcd12(load_val_i)) begin
                err_set = 1'b1;
            end else begin
                cnt_load = 1'b1;
                if (state == DONE) state_next = IDLE;
            end
        end else begin
            case (state)
                RUN: begin
                    if (stop_i) begin
                        state_next = PAUSE;
                    end else if (!mode_q && count == target_q) begin
                        // Started while already sitting on the target.
                        state_next = DONE;
                        done_set   = 1'b1;
                    end else if (presc == PRESC_LAST) begin
                        presc_next = '0;
                        if (mode_q && count == target_q) begin
                            cnt_clr  = 1'b1;
                            wrap_set = 1'b1;
                        end else begin
                            // 999 rolls over through the chain; carry_h flags the wrap.
                            cnt_inc = 1'b1;
                            if (!mode_q && bcd_inc12(count) == target_q) begin
                                state_next = DONE;
                                done_set   = 1'b1;
                            end
                        end
                    end else begin
                        presc_next = presc + 1'b1;
                    end
                end
                PAUSE: begin
                    if (start_i) state_next = RUN;
                end
                default: begin
                    if (start_i) begin
                        latch_tgt = 1'b1;
                        if (!is_bcd12(target_i)) begin
                            err_set = 1'b1;
                        end else begin
                            presc_next = '0;
                            state_next = RUN;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            target_q <= 12'h000;
            mode_q   <= 1'b0;
            err_o    <= 1'b0;
            done_o   <= 1'b0;
            wrap_o   <= 1'b0;
        end else begin
            state  <= state_next;
            presc  <= presc_next;
            done_o <= done_set;
            wrap_o <= wrap_set | carry_h;
            if (latch_tgt) begin
                target_q <= target_i;
                mode_q   <= wrap_mode_i;
            end
            if (clear_i) begin
                err_o <= 1'b0;
            end else if (err_set) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd999_ctrl.sv
// Directed bench: two instances (PRESCALE=1 and PRESCALE=3) share one stimulus bus.
module tb_bcd999_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    logic        clk, rst;
    logic        start_i, stop_i, clear_i, load_i, wrap_mode_i;
    logic [11:0] load_val_i, target_i;

    logic [3:0]  q1_a, q2_a, q3_a, q1_b, q2_b, q3_b;
    logic        running_a, done_a, wrap_a, err_a;
    logic        running_b, done_b, wrap_b, err_b;
    logic [1:0]  state_a, state_b;
    logic [11:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    assign cnt_a = {q3_a, q2_a, q1_a};
    assign cnt_b = {q3_b, q2_b, q1_b};

    bcd999_ctrl #(.PRESCALE(1)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
        .load_i(load_i), .load_val_i(load_val_i), .target_i(target_i),
        .wrap_mode_i(wrap_mode_i), .q1_o(q1_a), .q2_o(q2_a), .q3_o(q3_a),
        .running_o(running_a), .done_o(done_a), .wrap_o(wrap_a), .err_o(err_a),
        .state_o(state_a)
    );

    bcd999_ctrl #(.PRESCALE(3)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
        .load_i(load_i), .load_val_i(load_val_i), .target_i(target_i),
        .wrap_mode_i(wrap_mode_i), .q1_o(q1_b), .q2_o(q2_b), .q3_o(q3_b),
        .running_o(running_b), .done_o(done_b), .wrap_o(wrap_b), .err_o(err_b),
        .state_o(state_b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; load_i = 1'b0;
        load_val_i = 12'h000; target_i = 12'h000; wrap_mode_i = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [11:0] tgt, input logic mode);
        target_i = tgt; wrap_mode_i = mode; start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic pulse_load(input logic [11:0] val);
        load_val_i = val; load_i = 1'b1;
        step();
        load_i = 1'b0;
    endtask

    function automatic logic [11:0] to_bcd(input int d);
        return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if (cnt_a !== 12'h000 || running_a !== 1'b0 || done_a !== 1'b0 ||
            wrap_a !== 1'b0 || err_a !== 1'b0 || state_a !== S_IDLE) begin
            errors++;
            $display("FAIL reset_a cnt=%h run=%b done=%b wrap=%b err=%b st=%0d exp 000/0/0/0/0/0",
                     cnt_a, running_a, done_a, wrap_a, err_a, state_a);
        end
        checks++;
        if (cnt_b !== 12'h000 || running_b !== 1'b0 || state_b !== S_IDLE) begin
            errors++;
            $display("FAIL reset_b cnt=%h run=%b st=%0d exp 000/0/0", cnt_b, running_b, state_b);
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        pulse_start(12'h005, 1'b0);
        checks++;
        if (running_a !== 1'b1 || cnt_a !== 12'h000) begin
            errors++;
            $display("FAIL oneshot_start run=%b cnt=%h exp 1/000", running_a, cnt_a);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (cnt_a !== to_bcd(k) || done_a !== (k == 5)) begin
                errors++;
                $display("FAIL oneshot_count k=%0d cnt=%h done=%b exp %h/%b",
                         k, cnt_a, done_a, to_bcd(k), (k == 5));
            end
        end
        checks++;
        if (state_a !== S_DONE || running_a !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_state st=%0d run=%b exp 3/0", state_a, running_a);
        end
        step();
        step();
        checks++;
        if (cnt_a !== 12'h005 || done_a !== 1'b0 || running_a !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_hold cnt=%h done=%b run=%b exp 005/0/0", cnt_a, done_a, running_a);
        end
    endtask

    task automatic test_wrap_prescale();
        int d;
        logic exp_wrap;
        do_reset();
        pulse_start(12'h012, 1'b1);
        d = 0;
        for (int c = 1; c <= 45; c++) begin
            step();
            exp_wrap = 1'b0;
            if (c % 3 == 0) begin
                if (d == 12) begin
                    d = 0;
                    exp_wrap = 1'b1;
                end else begin
                    d++;
                end
            end
            checks++;
            if (cnt_b !== to_bcd(d) || wrap_b !== exp_wrap || running_b !== 1'b1) begin
                errors++;
                $display("FAIL wrap_presc c=%0d cnt=%h wrap=%b run=%b exp %h/%b/1",
                         c, cnt_b, wrap_b, running_b, to_bcd(d), exp_wrap);
            end
        end
    endtask

    task automatic test_carry();
        do_reset();
        pulse_load(12'h099);
        checks++;
        if (cnt_a !== 12'h099) begin
            errors++;
            $display("FAIL carry_load cnt=%h exp 099", cnt_a);
        end
        pulse_start(12'h999, 1'b0);
        step();
        checks++;
        if (cnt_a !== 12'h100) begin
            errors++;
            $display("FAIL carry_hund cnt=%h exp 100", cnt_a);
        end
        do_reset();
        pulse_load(12'h999);
        pulse_start(12'h999, 1'b1);
        step();
        checks++;
        if (cnt_a !== 12'h000 || wrap_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL wrap_999 cnt=%h wrap=%b done=%b exp 000/1/0", cnt_a, wrap_a, done_a);
        end
        step();
        checks++;
        if (cnt_a !== 12'h001 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL wrap_999_next cnt=%h wrap=%b exp 001/0", cnt_a, wrap_a);
        end
    endtask

    task automatic test_pause();
        do_reset();
        pulse_start(12'h999, 1'b0);
        step();
        step();
        // Next edge would tick; stop lands on the same edge.
        stop_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (cnt_b !== 12'h000 || state_b !== S_PAUSE || done_b !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold k=%0d cnt=%h st=%0d done=%b exp 000/2/0",
                         k, cnt_b, state_b, done_b);
            end
        end
        stop_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        checks++;
        if (cnt_b !== 12'h000 || running_b !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume cnt=%h run=%b exp 000/1", cnt_b, running_b);
        end
        step();
        checks++;
        if (cnt_b !== 12'h001) begin
            errors++;
            $display("FAIL pause_phase cnt=%h exp 001", cnt_b);
        end
    endtask

    task automatic test_load_in_run();
        do_reset();
        pulse_start(12'h999, 1'b0);
        step();
        step();
        pulse_load(12'h500);
        checks++;
        if (cnt_b !== 12'h001 || running_b !== 1'b1) begin
            errors++;
            $display("FAIL load_in_run cnt=%h run=%b exp 001/1", cnt_b, running_b);
        end
    endtask

    task automatic test_errors();
        do_reset();
        pulse_load(12'h045);
        pulse_load(12'h0A3);
        checks++;
        if (err_a !== 1'b1 || cnt_a !== 12'h045) begin
            errors++;
            $display("FAIL err_load err=%b cnt=%h exp 1/045", err_a, cnt_a);
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++;
        if (err_a !== 1'b0 || cnt_a !== 12'h000 || state_a !== S_IDLE) begin
            errors++;
            $display("FAIL err_clear err=%b cnt=%h st=%0d exp 0/000/0", err_a, cnt_a, state_a);
        end
        pulse_start(12'h1F0, 1'b0);
        step();
        checks++;
        if (err_a !== 1'b1 || state_a !== S_IDLE || running_a !== 1'b0 || cnt_a !== 12'h000) begin
            errors++;
            $display("FAIL err_target err=%b st=%0d run=%b cnt=%h exp 1/0/0/000",
                     err_a, state_a, running_a, cnt_a);
        end
    endtask

    task automatic test_start_at_target();
        do_reset();
        pulse_start(12'h000, 1'b0);
        checks++;
        if (running_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL at_target_run run=%b done=%b exp 1/0", running_a, done_a);
        end
        step();
        checks++;
        if (state_a !== S_DONE || done_a !== 1'b1 || cnt_a !== 12'h000) begin
            errors++;
            $display("FAIL at_target_done st=%0d done=%b cnt=%h exp 3/1/000", state_a, done_a, cnt_a);
        end
    endtask

    task automatic test_rst_mid_run();
        do_reset();
        pulse_start(12'h999, 1'b1);
        step();
        step();
        step();
        checks++;
        if (cnt_a !== 12'h003) begin
            errors++;
            $display("FAIL mid_run_count cnt=%h exp 003", cnt_a);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (cnt_a !== 12'h000 || running_a !== 1'b0 || done_a !== 1'b0 ||
            wrap_a !== 1'b0 || err_a !== 1'b0 || state_a !== S_IDLE) begin
            errors++;
            $display("FAIL mid_run_rst cnt=%h run=%b done=%b wrap=%b err=%b st=%0d exp 000/0/0/0/0/0",
                     cnt_a, running_a, done_a, wrap_a, err_a, state_a);
        end
        step();
        checks++;
        if (cnt_a !== 12'h000 || running_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_after cnt=%h run=%b exp 000/0", cnt_a, running_a);
        end
    endtask

    task automatic test_clear_on_tick();
        do_reset();
        pulse_start(12'h999, 1'b0);
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (cnt_b !== 12'h001) begin
            errors++;
            $display("FAIL clear_tick_pre cnt=%h exp 001", cnt_b);
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++;
        if (cnt_b !== 12'h000 || running_b !== 1'b0 || state_b !== S_IDLE ||
            wrap_b !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL clear_tick cnt=%h run=%b st=%0d wrap=%b done=%b exp 000/0/0/0/0",
                     cnt_b, running_b, state_b, wrap_b, done_b);
        end
        step();
        step();
        step();
        checks++;
        if (cnt_b !== 12'h000 || state_b !== S_IDLE) begin
            errors++;
            $display("FAIL clear_tick_idle cnt=%h st=%0d exp 000/0", cnt_b, state_b);
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; load_i = 1'b0;
        load_val_i = 12'h000; target_i = 12'h000; wrap_mode_i = 1'b0;
        test_reset();
        test_oneshot();
        test_wrap_prescale();
        test_carry();
        test_pause();
        test_load_in_run();
        test_errors();
        test_start_at_target();
        test_rst_mid_run();
        test_clear_on_tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
